// File: rtl/md_seq_ctrl.sv
// -----------------------------------------------------------------------------
// md_seq_ctrl
// Multiply/divide sequencer that sits beside the ALU in the EX stage.
//
// An MD operation is accepted in one cycle. Its 64-bit result is computed from
// the operands present in that cycle and held in a pending register. The block
// then stays busy for a fixed latency before it commits the result to HI/LO.
// MTHI/MTLO write HI/LO directly on the accepting edge. While an MD-class
// instruction sits in decode and an operation is in flight or being accepted,
// md_stall freezes decode.
//
// Ports
//   clk       in   1   clock, rising edge
//   reset     in   1   synchronous, active-low
//   start     in   1   EX holds a valid MD instruction this cycle
//   md_op     in   3   0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6/7 none
//   rs_val    in   32  rs operand (multiplicand / dividend / mt source)
//   rt_val    in   32  rt operand (multiplier / divisor)
//   md_use_d  in   1   decode holds an MD-class instruction
//   busy      out  1   mult/div in flight (registered)
//   done      out  1   one-cycle pulse after HI/LO commit (registered)
//   hi, lo    out  32  HI/LO architectural registers (registered)
//   md_stall  out  1   decode stall request (combinational)
//
// Handshake: start is a one-sided request with no ready. It is taken only
// when the block is idle (busy==0). A start seen while busy is dropped, and
// the pipeline keeps that from happening by honouring md_stall. A new start is
// taken in the same cycle that busy falls.
// -----------------------------------------------------------------------------
module md_seq_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_d,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        md_stall
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q;
  logic [CW-1:0] cnt_q;
  logic        busy_q, done_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi_q, pend_lo_q;
  logic        pend_wr_q;   // cleared for divide-by-zero so that HI/LO are kept

  // ---------------------------------------------------------------------------
  // Result datapath, evaluated from the operands in the accepting cycle
  // ---------------------------------------------------------------------------
  logic [63:0] prod_s, prod_u;
  logic        div_signed;
  logic [31:0] rs_mag, rt_mag, dvd, dvs, q_mag, r_mag, quot_d, rem_d;

  // A signed 32x32 product equals the low 64 bits of the product of the
  // sign-extended operands.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // One unsigned divider serves both flavours. Signed division runs on the
  // magnitudes and then fixes up the signs. This also gives the MIPS answer
  // for 0x80000000 / -1: the magnitude quotient 0x80000000 negates to itself.
  assign div_signed = (md_op == OP_DIV);
  assign rs_mag     = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign rt_mag     = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign dvd        = div_signed ? rs_mag : rs_val;
  assign dvs        = div_signed ? rt_mag : rt_val;

  always_comb begin
    q_mag = 32'd0;
    r_mag = 32'd0;
    if (dvs != 32'd0) begin
      q_mag = dvd / dvs;
      r_mag = dvd % dvs;
    end
    quot_d = q_mag;
    rem_d  = r_mag;
    if (div_signed) begin
      if (rs_val[31] ^ rt_val[31]) quot_d = 32'd0 - q_mag;
      if (rs_val[31])              rem_d  = 32'd0 - r_mag;   // remainder follows dividend
    end
  end

  // ---------------------------------------------------------------------------
  // Sequencer FSM with its registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            case (md_op)
              OP_MULT, OP_MULTU: begin
                pend_hi_q <= (md_op == OP_MULT) ? prod_s[63:32] : prod_u[63:32];
                pend_lo_q <= (md_op == OP_MULT) ? prod_s[31:0]  : prod_u[31:0];
                pend_wr_q <= 1'b1;
                cnt_q     <= CW'(MULT_CYCLES - 1);
                busy_q    <= 1'b1;
                state_q   <= RUN;
              end
              OP_DIV, OP_DIVU: begin
                pend_hi_q <= rem_d;
                pend_lo_q <= quot_d;
                pend_wr_q <= (rt_val != 32'd0);
                cnt_q     <= CW'(DIV_CYCLES - 1);
                busy_q    <= 1'b1;
                state_q   <= RUN;
              end
              OP_MTHI: hi_q <= rs_val;
              OP_MTLO: lo_q <= rs_val;
              default: ;
            endcase
          end
        end
        RUN: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            if (pend_wr_q) begin
              hi_q <= pend_hi_q;
              lo_q <= pend_lo_q;
            end
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  // Stall decode while an operation is in flight or about to start. A mult or
  // div start has md_op[2]==0.
  assign md_stall = md_use_d & (busy_q | (start & ~md_op[2] & ~busy_q));

endmodule

// File: tb/tb_md_seq_ctrl.sv
module tb_md_seq_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        md_use_d;
  logic        busy, done, md_stall;
  logic [31:0] hi, lo;

  int errors = 0;
  int checks = 0;

  // clock / reset block
  always #5 clk = ~clk;

  md_seq_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_d (md_use_d),
    .busy     (busy),
    .done     (done),
    .hi       (hi),
    .lo       (lo),
    .md_stall (md_stall)
  );

  // Advance one clock. Outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
      $error("%s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Start a mult/div from the current (idle) cycle and check n busy cycles.
  // The task returns in the cycle where done is high and HI/LO are committed.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int n,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    step();
    start = 1'b0; md_op = 3'd7;
    check({tag, "_done_low"}, {31'd0, done}, 32'd0);
    for (int i = 0; i < n; i++) begin
      check({tag, "_busy"}, {31'd0, busy}, 32'd1);
      if (i < n - 1) step();
    end
    step();
    check({tag, "_busy_fall"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd1);
    check({tag, "_hi"}, hi, exp_hi);
    check({tag, "_lo"}, lo, exp_lo);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; md_op = 3'd7; rs_val = '0; rt_val = '0; md_use_d = 1'b0;

    // 1: reset, then a signed MULT
    step(); step();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b1;
    run_op("mult", 3'd0, 32'hFFFF_FFFF, 32'd2, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

    // 2: MULTU, started in the same cycle that busy fell
    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 5, 32'h0000_0001, 32'hFFFF_FFFE);
    step();
    check("multu_done_pulse", {31'd0, done}, 32'd0);

    // 3: divisions
    run_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu_by0", 3'd3, 32'd7, 32'd0, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 10, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'h0000_0000, 32'h8000_0000);
    run_op("divu_big", 3'd3, 32'hFFFF_FFFF, 32'h10, 10, 32'h0000_000F, 32'h0FFF_FFFF);
    run_op("div_by0", 3'd2, 32'hFFFF_FFF9, 32'd0, 10, 32'h0000_000F, 32'h0FFF_FFFF);

    // 4: MTHI / MTLO / ignored op
    step();
    start = 1'b1; md_op = 3'd4; rs_val = 32'h1234_5678;
    step();
    start = 1'b0;
    check("mthi_hi", hi, 32'h1234_5678);
    check("mthi_lo", lo, 32'h0FFF_FFFF);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    check("mthi_done", {31'd0, done}, 32'd0);
    start = 1'b1; md_op = 3'd5; rs_val = 32'hCAFE_F00D;
    step();
    start = 1'b0;
    check("mtlo_lo", lo, 32'hCAFE_F00D);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    start = 1'b1; md_op = 3'd6; rs_val = 32'hDEAD_BEEF; rt_val = 32'd3;
    step();
    start = 1'b0;
    check("op6_hi", hi, 32'h1234_5678);
    check("op6_lo", lo, 32'hCAFE_F00D);
    check("op6_busy", {31'd0, busy}, 32'd0);
    check("op6_done", {31'd0, done}, 32'd0);

    // 5: md_stall during a MULT, with a second start issued while running
    md_use_d = 1'b1;
    #1 check("stall_idle", {31'd0, md_stall}, 32'd0);
    start = 1'b1; md_op = 3'd0; rs_val = 32'd3; rt_val = 32'd4;
    #1 check("stall_start", {31'd0, md_stall}, 32'd1);
    step();
    start = 1'b0; md_op = 3'd7;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        start = 1'b1; md_op = 3'd3; rs_val = 32'd100; rt_val = 32'd7;
      end
      #1;
      check("stall_busy", {31'd0, md_stall}, 32'd1);
      check("stall_busy_b", {31'd0, busy}, 32'd1);
      step();
      start = 1'b0; md_op = 3'd7;
    end
    #1;
    check("stall_fall", {31'd0, md_stall}, 32'd0);
    check("stall_busy_fall", {31'd0, busy}, 32'd0);
    check("stall_done", {31'd0, done}, 32'd1);
    check("stall_hi", hi, 32'd0);
    check("stall_lo", lo, 32'd12);
    step();
    check("ign_busy", {31'd0, busy}, 32'd0);
    check("ign_done", {31'd0, done}, 32'd0);
    check("ign_lo", lo, 32'd12);
    md_use_d = 1'b0;

    // 6: reset on the third busy cycle of a DIV aborts it
    start = 1'b1; md_op = 3'd2; rs_val = 32'd50; rt_val = 32'd5;
    step();
    start = 1'b0;
    step(); step();
    check("abort_busy3", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("abort_no_done", {31'd0, done}, 32'd0);
      check("abort_no_busy", {31'd0, busy}, 32'd0);
    end
    check("abort_lo_end", lo, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Watchdog so that the bench always ends
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
